// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, prot default and the bridge state encoding.
package axi_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } axi_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/wb_to_axi_lite_master.sv
// Pipelined Wishbone slave port to AXI4-Lite master bridge, one transaction in flight.
module wb_to_axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int BYTE_WIDTH    = DATA_WIDTH/8,
  parameter int LOG_BYTE_W    = $clog2(BYTE_WIDTH),
  parameter int WB_ADDR_WIDTH = ADDR_WIDTH-LOG_BYTE_W
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0]    wb_dat_i,
  input  logic [BYTE_WIDTH-1:0]    wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic [DATA_WIDTH-1:0]    wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_stall_o,
  output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [BYTE_WIDTH-1:0]    m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  output logic                     resp_err_o
);

  axi_state_e              state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [BYTE_WIDTH-1:0]   wstrb_q;
  logic                    aw_done, w_done, cyc_lost;
  logic                    aw_fire, w_fire;

  assign aw_fire = m_axi_awvalid & m_axi_awready;
  assign w_fire  = m_axi_wvalid & m_axi_wready;

  // Latched request feeds both address channels; stable for the whole transaction.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = AXI_PROT_DEFAULT;
  assign m_axi_arprot = AXI_PROT_DEFAULT;

  // The ack cycle is already IDLE, but must not accept a new request.
  assign wb_stall_o = (state != ST_IDLE) | wb_ack_o;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      cyc_lost      <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      wb_ack_o      <= 1'b0;
      wb_dat_o      <= '0;
      resp_err_o    <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      if (state != ST_IDLE && !wb_cyc_i) cyc_lost <= 1'b1;
      unique case (state)
        ST_IDLE: if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
          addr_q   <= {wb_adr_i, {LOG_BYTE_W{1'b0}}};
          wdata_q  <= wb_dat_i;
          wstrb_q  <= wb_sel_i;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          cyc_lost <= 1'b0;
          if (wb_we_i) begin
            state         <= ST_WR;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
          end else begin
            state         <= ST_RD_ADDR;
            m_axi_arvalid <= 1'b1;
          end
        end
        ST_WR: begin
          if (aw_fire) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_fire) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done | aw_fire) && (w_done | w_fire)) begin
            state        <= ST_WB_RESP;
            m_axi_bready <= 1'b1;
          end
        end
        ST_WB_RESP: if (m_axi_bvalid && m_axi_bready) begin
          m_axi_bready <= 1'b0;
          wb_ack_o     <= wb_cyc_i & ~cyc_lost;
          resp_err_o   <= resp_err_o | resp_is_err(m_axi_bresp);
          state        <= ST_IDLE;
        end
        ST_RD_ADDR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          state         <= ST_RD_DATA;
        end
        ST_RD_DATA: if (m_axi_rvalid && m_axi_rready) begin
          wb_dat_o     <= m_axi_rdata;
          m_axi_rready <= 1'b0;
          wb_ack_o     <= wb_cyc_i & ~cyc_lost;
          resp_err_o   <= resp_err_o | resp_is_err(m_axi_rresp);
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
